// File: rtl/demux_1_to_k_buffered_if.sv
// Producer/consumer bundle for the 1-to-K buffered distributor.
// slave: the distributor itself; master: the producer plus the K consumers.
interface demux_1_to_k_buffered_if #(
  parameter int K    = 4,
  parameter int SIZE = 16
);
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  logic [SIZE-1:0]   in_data;
  logic [SW-1:0]     in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [K*SIZE-1:0] out_bus;
  logic [K-1:0]      out_valid;
  logic [K-1:0]      out_ready;
  logic              err_sel;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_bus, out_valid, err_sel
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_bus, out_valid, err_sel
  );
endinterface

// File: rtl/demux_1_to_k_buffered.sv
// Steers one word per cycle into K 2-entry lane FIFOs; visible on its lane one cycle after the push.
// in_ready drops only while the selected lane is full (no pass-through); out-of-range selects are dropped and flagged.
module demux_1_to_k_buffered #(
  parameter int K    = 4,
  parameter int SIZE = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  demux_1_to_k_buffered_if.slave   bus
);
  logic [SIZE-1:0] mem_q [K][2];
  logic [1:0]      cnt_q [K];
  logic [1:0]      cnt_d [K];
  logic [K-1:0]    wptr_q, wptr_d;
  logic [K-1:0]    rptr_q, rptr_d;
  logic            err_q, err_d;

  logic            in_range;
  logic            in_ready;
  logic [K-1:0]    push;
  logic [K-1:0]    pop;
  logic [K*SIZE-1:0] out_bus;
  logic [K-1:0]    out_valid;

  assign in_range = int'(bus.in_sel) < K;

  // Readiness looks only at registered lane state, never at out_ready.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < K; i++) begin
      if (int'(bus.in_sel) == i) begin
        in_ready = (cnt_q[i] != 2'd2);
      end
    end
  end

  always_comb begin
    push    = '0;
    pop     = '0;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    out_bus = '0;
    out_valid = '0;
    for (int i = 0; i < K; i++) begin
      push[i]      = bus.in_valid && in_ready && (int'(bus.in_sel) == i);
      out_valid[i] = (cnt_q[i] != 2'd0);
      pop[i]       = out_valid[i] && bus.out_ready[i];
      cnt_d[i]     = cnt_q[i] + 2'(push[i]) - 2'(pop[i]);
      wptr_d[i]    = wptr_q[i] ^ push[i];
      rptr_d[i]    = rptr_q[i] ^ pop[i];
      out_bus[i*SIZE +: SIZE] = mem_q[i][rptr_q[i]];
    end
    err_d = err_q | (bus.in_valid && in_ready && !in_range);
  end

  // Storage is cleared too so the lane heads read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        cnt_q[i]    <= '0;
        mem_q[i][0] <= '0;
        mem_q[i][1] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < K; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) begin
          mem_q[i][wptr_q[i]] <= bus.in_data;
        end
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_bus   = out_bus;
  assign bus.out_valid = out_valid;
  assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_demux_1_to_k_buffered.sv
// Directed bench for the 1-to-K buffered distributor, covering a K=4 and a K=3 instance.
module tb_demux_1_to_k_buffered;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  demux_1_to_k_buffered_if #(.K(4), .SIZE(16)) if4 ();
  demux_1_to_k_buffered_if #(.K(3), .SIZE(16)) if3 ();

  demux_1_to_k_buffered #(.K(4), .SIZE(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  demux_1_to_k_buffered #(.K(3), .SIZE(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if4.in_data = '0; if4.in_sel = '0; if4.in_valid = 1'b0; if4.out_ready = '0;
    if3.in_data = '0; if3.in_sel = '0; if3.in_valid = 1'b0; if3.out_ready = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid4", 64'(if4.out_valid), 64'h0);
    chk("rst_out_bus4", 64'(if4.out_bus), 64'h0);
    chk("rst_err4", 64'(if4.err_sel), 64'h0);
    chk("rst_out_valid3", 64'(if3.out_valid), 64'h0);
    for (int s = 0; s < 4; s++) begin
      if4.in_sel = 2'(s);
      #1;
      chk($sformatf("rst_in_ready_sel%0d", s), 64'(if4.in_ready), 64'h1);
    end

    // Single route to lane 2
    tick();
    if4.in_data = 16'hA5A5; if4.in_sel = 2'd2; if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    #1;
    chk("route_valid", 64'(if4.out_valid), 64'h4);
    chk("route_head", 64'(if4.out_bus[47:32]), 64'hA5A5);
    if4.out_ready = 4'b0100;
    tick();
    if4.out_ready = 4'b0000;
    #1;
    chk("route_pop_valid", 64'(if4.out_valid), 64'h0);

    // Fill lane 1 and hold the third word under backpressure
    if4.in_sel = 2'd1; if4.in_valid = 1'b1; if4.in_data = 16'h0001;
    tick();
    if4.in_data = 16'h0002;
    tick();
    if4.in_data = 16'h0003;
    #1;
    chk("fill_in_ready_full", 64'(if4.in_ready), 64'h0);
    chk("fill_valid", 64'(if4.out_valid), 64'h2);
    chk("fill_head1", 64'(if4.out_bus[31:16]), 64'h0001);
    tick();
    chk("fill_still_held", 64'(if4.in_ready), 64'h0);
    if4.out_ready = 4'b0010;
    tick();
    if4.out_ready = 4'b0000;
    #1;
    chk("fill_head2", 64'(if4.out_bus[31:16]), 64'h0002);
    chk("fill_in_ready_rise", 64'(if4.in_ready), 64'h1);
    tick();
    if4.in_valid = 1'b0;
    #1;
    chk("fill_full_again", 64'(if4.in_ready), 64'h0);
    chk("fill_head_kept", 64'(if4.out_bus[31:16]), 64'h0002);
    if4.out_ready = 4'b0010;
    tick();
    chk("fill_head3", 64'(if4.out_bus[31:16]), 64'h0003);
    tick();
    if4.out_ready = 4'b0000;
    #1;
    chk("fill_drained", 64'(if4.out_valid), 64'h0);

    // Simultaneous push and pop on lane 0 at count 1
    if4.in_sel = 2'd0; if4.in_data = 16'h1111; if4.in_valid = 1'b1;
    tick();
    if4.in_data = 16'h2222; if4.out_ready = 4'b0001;
    #1;
    chk("pp_in_ready", 64'(if4.in_ready), 64'h1);
    tick();
    if4.in_valid = 1'b0; if4.out_ready = 4'b0000;
    #1;
    chk("pp_valid", 64'(if4.out_valid), 64'h1);
    chk("pp_head", 64'(if4.out_bus[15:0]), 64'h2222);
    chk("pp_count_one", 64'(if4.in_ready), 64'h1);
    if4.out_ready = 4'b0001;
    tick();
    if4.out_ready = 4'b0000;
    #1;
    chk("pp_drained", 64'(if4.out_valid), 64'h0);

    // All four lanes loaded, then popped together
    if4.in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if4.in_sel = 2'(s);
      if4.in_data = 16'((s + 1) * 16);
      tick();
    end
    if4.in_valid = 1'b0;
    #1;
    chk("par_valid", 64'(if4.out_valid), 64'hF);
    chk("par_bus", 64'(if4.out_bus), 64'h0040_0030_0020_0010);
    if4.out_ready = 4'b1111;
    tick();
    if4.out_ready = 4'b0000;
    #1;
    chk("par_drained", 64'(if4.out_valid), 64'h0);
    chk("par_err4", 64'(if4.err_sel), 64'h0);

    // Out-of-range select on the K=3 instance
    if3.in_sel = 2'd3; if3.in_data = 16'hDEAD; if3.in_valid = 1'b1;
    #1;
    chk("oor_in_ready", 64'(if3.in_ready), 64'h1);
    chk("oor_err_before", 64'(if3.err_sel), 64'h0);
    tick();
    if3.in_valid = 1'b0;
    #1;
    chk("oor_err_set", 64'(if3.err_sel), 64'h1);
    chk("oor_no_lane", 64'(if3.out_valid), 64'h0);
    if3.in_valid = 1'b1; if3.in_sel = 2'd0; if3.in_data = 16'h0007;
    tick();
    if3.in_sel = 2'd2; if3.in_data = 16'h0009;
    tick();
    if3.in_valid = 1'b0;
    #1;
    chk("oor_lanes", 64'(if3.out_valid), 64'h5);
    chk("oor_bus", 64'(if3.out_bus), 64'h0009_0000_0007);
    chk("oor_err_sticky", 64'(if3.err_sel), 64'h1);

    // Asynchronous reset pulse with lanes non-empty
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(if3.out_valid), 64'h0);
    chk("mid_rst_err", 64'(if3.err_sel), 64'h0);
    chk("mid_rst_bus", 64'(if3.out_bus), 64'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(if3.out_valid), 64'h0);
    if3.in_sel = 2'd1;
    #1;
    chk("post_rst_in_ready", 64'(if3.in_ready), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_1_to_k_buffered.md
Name: demux_1_to_k_buffered

Overview:
- Registered 1-to-K stream distributor, the write-side counterpart of the K-to-1 selector in the datapath.
- Accepts one SIZE-bit word per cycle with a destination index and steers it into one of K per-lane 2-entry FIFOs.
- Lanes are exposed on a flattened output bus (lane i at bits i*SIZE +: SIZE), each with its own valid/ready handshake.
- Sits between a single producer and K independent consumers.

Parameters:
- K, 4, number of output lanes (K >= 2; need not be a power of two).
- SIZE, 16, width of each data word.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  SIZE  word to route.
- in_sel  input  $clog2(K)  destination lane index.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out_bus  output  K*SIZE  flattened lane heads; lane i at [i*SIZE +: SIZE].
- out_valid  output  K  lane i head is valid.
- out_ready  input  K  consumer i takes lane i head this cycle.
- err_sel  output  1  sticky flag: an out-of-range in_sel was accepted.

Behaviour:
- Reset (rst_n low, asynchronous): all lane counts 0, all read/write pointers 0, out_valid = 0, out_bus = 0, err_sel = 0. Storage contents need not be cleared, but out_bus must read 0 while out_valid is 0 after reset.
- Lane state: per lane i, a 2-entry storage array, a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2).
- in_ready (combinational from registered state and in_sel only; no dependency on out_ready):
  - If in_sel >= K: in_ready = 1.
  - Otherwise: in_ready = (count[in_sel] != 2).
- Push: when in_valid && in_ready && in_sel < K, write in_data to lane in_sel at its write pointer, toggle that pointer and increment that count at the clock edge.
- Drop: when in_valid && in_ready && in_sel >= K, discard the word and set err_sel = 1. err_sel holds until reset.
- Pop: for each lane i with out_valid[i] && out_ready[i], toggle read pointer i and decrement count i at the clock edge.
- out_valid[i] = (count[i] != 0). out_bus lane i = storage[i][rdptr[i]]; that slice is don't-care but stable when out_valid[i] = 0.
- Latency: a word pushed at edge N is visible on its lane from cycle N+1, provided the lane was empty.
- Same lane, simultaneous push and pop:
  - count 1: count stays 1, both pointers advance.
  - count 2: push is refused (in_ready = 0 from registered full); pop proceeds and count becomes 1. No same-cycle pass-through.
- Different lanes push and pop independently in the same cycle. All K lanes may pop in one cycle.
- Ordering: words to the same lane leave in arrival order. There is no ordering relation between lanes.
- Consumer rule: out_valid[i] never drops without a pop, and the lane i head stays stable until popped.
- Producer rule: the producer must hold in_data and in_sel stable while in_valid && !in_ready.
- Reset mid-operation: all buffered words are lost, every lane is empty in the cycle after rst_n deasserts, and err_sel clears.
- in_valid = 0: no state change except pops.

Test Plan:
- Reset then idle:
  - rst_n low 3 cycles, then high -> out_valid = 0000, in_ready = 1 for every in_sel < 4, err_sel = 0.
- Single route:
  - Push 0xA5A5 with sel = 2 at edge N -> from cycle N+1 out_valid = 0100 and out_bus[47:32] = 0xA5A5.
  - Pop -> out_valid = 0000.
- Fill and backpressure:
  - out_ready = 0, push 0x0001, 0x0002, 0x0003 to sel = 1 -> third push sees in_ready = 0 and is held.
  - Raise out_ready[1] for one cycle -> 0x0001 leaves, 0x0002 becomes head, in_ready rises the next cycle and 0x0003 is then accepted.
- Simultaneous push/pop at count 1:
  - Lane 0 holds 0x1111, out_ready[0] = 1, push 0x2222 to sel = 0 -> next cycle head = 0x2222, count = 1, no word lost.
- Parallel lanes:
  - Push 0x10, 0x20, 0x30, 0x40 to sels 0..3, then assert out_ready = 1111 for one cycle -> all four pops in that cycle, out_valid = 0000 afterwards.
- Out-of-range select (K = 3):
  - Push with sel = 3 -> in_ready = 1, no lane changes, err_sel = 1 from the next cycle.
  - Pulse rst_n mid-stream with lanes non-empty -> out_valid = 000 and err_sel = 0 immediately.
